// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the P7 pipeline control path: exception state
// encoding, Tuse/MDU-kind codes, the exception handler vector and the
// per-source data-hazard compare used by the hazard controller.
package pipe_ctrl_pkg;

  // Exception sequencer states; RECOVER lasts exactly one cycle after a flush.
  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } exc_state_e;

  // Tuse value meaning "this source register is not read".
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // MDU operation kind as presented on E_md_kind.
  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  // Handler fetch address loaded by every pipeline register on req.
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  // One source operand of the D instruction conflicts with a producer in E or
  // M whose result will not be forwardable by the time D needs it. Register 0
  // is hard-wired, so it never conflicts; an unused source never conflicts.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] e_dst,
    input logic [1:0] e_tnew,
    input logic [4:0] m_dst,
    input logic [1:0] m_tnew
  );
    logic e_hit;
    logic m_hit;
    e_hit = (src == e_dst) && (e_tnew > tuse);
    m_hit = (src == m_dst) && (m_tnew > tuse);
    return (src != 5'd0) && (tuse != TUSE_NONE) && (e_hit || m_hit);
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Multiply/divide busy tracker: loads a cycle count when an MDU op starts in
// E and counts down to zero. md_busy covers the start cycle plus every cycle
// the count is non-zero.
module md_busy_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_kind,
  input  logic req,
  output logic md_busy
);

  logic [CNT_W-1:0] md_cnt;
  logic             cnt_idle;
  logic             load;
  logic [CNT_W-1:0] load_val;

  assign cnt_idle = (md_cnt == '0);
  // A start coinciding with an exception flush is squashed with its instruction;
  // a start while already counting cannot happen and is ignored.
  assign load     = md_start && !req && cnt_idle;
  assign load_val = (md_kind == MD_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  assign md_busy  = !cnt_idle || (md_start && !req);

  // Countdown register: load on a fresh start, otherwise decrement to zero.
  // An in-flight op is deliberately not cleared by req.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    if (!reset) begin
      md_cnt <= '0;
    end else if (load) begin
      md_cnt <= load_val;
    end else if (!cnt_idle) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/exception sequencer for the five-stage P7 pipeline.
// Produces the F-PC/F-D hold (stall), the D/E bubble (E_flush) and the global
// exception flush (req), with a one-cycle RECOVER state after each flush.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_tuse_rs,
  input  logic [1:0] D_tuse_rt,
  input  logic       D_is_md,
  input  logic [4:0] E_dst,
  input  logic [1:0] E_tnew,
  input  logic [4:0] M_dst,
  input  logic [1:0] M_tnew,
  input  logic       E_md_start,
  input  logic       E_md_kind,
  input  logic       int_req,
  output logic       stall,
  output logic       E_flush,
  output logic       req,
  output logic       md_busy,
  output logic       exc_state
);

  exc_state_e state;
  logic       in_recover;
  logic       stall_rs;
  logic       stall_rt;
  logic       stall_md;
  logic       md_busy_raw;

  assign in_recover = (state == RECOVER);

  md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_cnt (
    .clk      (clk),
    .reset    (reset),
    .md_start (E_md_start),
    .md_kind  (E_md_kind),
    .req      (req),
    .md_busy  (md_busy_raw)
  );

  // Hazard detection, exception request and stall arbitration. All outputs
  // are held low while reset is asserted so the pipeline sees a quiet
  // controller immediately, independent of the clock.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    req      = 1'b0;
    stall    = 1'b0;
    stall_rs = src_hazard(D_rs, D_tuse_rs, E_dst, E_tnew, M_dst, M_tnew);
    stall_rt = src_hazard(D_rt, D_tuse_rt, E_dst, E_tnew, M_dst, M_tnew);
    stall_md = D_is_md && md_busy_raw;
    if (reset && !in_recover) begin
      // req wins over any stall: every register is cleared regardless.
      req   = int_req;
      stall = !int_req && (stall_rs || stall_rt || stall_md);
    end
  end

  assign E_flush   = stall;
  assign md_busy   = reset && md_busy_raw;
  assign exc_state = in_recover;

  // Exception sequencer: each req is followed by exactly one RECOVER cycle in
  // which int_req is masked, so req pulses are never back-to-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (int_req) state <= RECOVER;
        RECOVER: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Each step drives the inputs,
// pushes the expected outputs into a scoreboard queue, and the checker pops
// and compares once the combinational outputs have settled mid-cycle.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic stall;
    logic e_flush;
    logic req;
    logic md_busy;
    logic exc_state;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [1:0] D_tuse_rs;
  logic [1:0] D_tuse_rt;
  logic       D_is_md;
  logic [4:0] E_dst;
  logic [1:0] E_tnew;
  logic [4:0] M_dst;
  logic [1:0] M_tnew;
  logic       E_md_start;
  logic       E_md_kind;
  logic       int_req;
  logic       stall;
  logic       E_flush;
  logic       req;
  logic       md_busy;
  logic       exc_state;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  pipe_hazard_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_tuse_rs  (D_tuse_rs),
    .D_tuse_rt  (D_tuse_rt),
    .D_is_md    (D_is_md),
    .E_dst      (E_dst),
    .E_tnew     (E_tnew),
    .M_dst      (M_dst),
    .M_tnew     (M_tnew),
    .E_md_start (E_md_start),
    .E_md_kind  (E_md_kind),
    .int_req    (int_req),
    .stall      (stall),
    .E_flush    (E_flush),
    .req        (req),
    .md_busy    (md_busy),
    .exc_state  (exc_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic s, input logic rq, input logic bz, input logic ex);
    exp_t e;
    e.stall     = s;
    e.e_flush   = s;
    e.req       = rq;
    e.md_busy   = bz;
    e.exc_state = ex;
    return e;
  endfunction

  task automatic idle_inputs();
    D_rs       = 5'd0;
    D_rt       = 5'd0;
    D_tuse_rs  = 2'd3;
    D_tuse_rt  = 2'd3;
    D_is_md    = 1'b0;
    E_dst      = 5'd0;
    E_tnew     = 2'd0;
    M_dst      = 5'd0;
    M_tnew     = 2'd0;
    E_md_start = 1'b0;
    E_md_kind  = 1'b0;
    int_req    = 1'b0;
  endtask

  // Pop the oldest expectation and compare every output against it.
  task automatic compare_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".stall"},     32'(stall),     32'(e.stall));
      check({tag, ".E_flush"},   32'(E_flush),   32'(e.e_flush));
      check({tag, ".req"},       32'(req),       32'(e.req));
      check({tag, ".md_busy"},   32'(md_busy),   32'(e.md_busy));
      check({tag, ".exc_state"}, 32'(exc_state), 32'(e.exc_state));
    end
  endtask

  // Inputs for this cycle are already driven; check now, then advance to
  // one time unit past the next rising edge.
  task automatic cyc(input string tag, input exp_t e);
    exp_q.push_back(e);
    #1;
    compare_out(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic now_chk(input string tag, input exp_t e);
    exp_q.push_back(e);
    #1;
    compare_out(tag);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    reset = 1'b0;
    #2;
    now_chk("reset", mk(0, 0, 0, 0));
    #10 reset = 1'b1;          // released at t=13, between edges
    @(posedge clk);
    #1;

    // Load-use on rs: E producer not ready, then M producer not ready, then ready.
    D_rs = 5'd5; D_tuse_rs = 2'd0; E_dst = 5'd5; E_tnew = 2'd2;
    cyc("loaduse_E", mk(1, 0, 0, 0));
    E_dst = 5'd0; E_tnew = 2'd0; M_dst = 5'd5; M_tnew = 2'd1;
    cyc("loaduse_M1", mk(1, 0, 0, 0));
    M_tnew = 2'd0;
    cyc("loaduse_M0", mk(0, 0, 0, 0));

    // rt path: Tuse 1 vs Tnew 2 stalls; Tuse 2 vs Tnew 2 does not; Tuse 3 never.
    idle_inputs();
    D_rt = 5'd7; D_tuse_rt = 2'd1; M_dst = 5'd7; M_tnew = 2'd2;
    cyc("rt_stall", mk(1, 0, 0, 0));
    D_tuse_rt = 2'd2;
    cyc("rt_equal", mk(0, 0, 0, 0));
    D_tuse_rt = 2'd3; E_dst = 5'd7; E_tnew = 2'd2;
    cyc("rt_unused", mk(0, 0, 0, 0));

    // Register 0 never stalls.
    idle_inputs();
    D_rs = 5'd0; D_tuse_rs = 2'd0; E_dst = 5'd0; E_tnew = 2'd2;
    cyc("zero_reg", mk(0, 0, 0, 0));

    // Divide: busy for the start cycle plus 10 countdown cycles.
    idle_inputs();
    D_is_md = 1'b1; E_md_start = 1'b1; E_md_kind = 1'b1;
    cyc("div_start", mk(1, 0, 1, 0));
    E_md_start = 1'b0;
    for (int i = 0; i < 10; i++) cyc($sformatf("div_busy%0d", i), mk(1, 0, 1, 0));
    cyc("div_done", mk(0, 0, 0, 0));

    // Exception during a stall: req beats stall, RECOVER masks int_req.
    idle_inputs();
    D_rs = 5'd5; D_tuse_rs = 2'd0; E_dst = 5'd5; E_tnew = 2'd2; int_req = 1'b1;
    cyc("exc_req", mk(0, 1, 0, 0));
    cyc("exc_recover", mk(0, 0, 0, 1));
    cyc("exc_req2", mk(0, 1, 0, 0));
    int_req = 1'b0;
    cyc("exc_recover2", mk(0, 0, 0, 1));
    cyc("exc_run_stall", mk(1, 0, 0, 0));

    // MDU start in the req cycle is dropped.
    idle_inputs();
    E_md_start = 1'b1; int_req = 1'b1;
    cyc("md_drop_req", mk(0, 1, 0, 0));
    E_md_start = 1'b0; int_req = 1'b0;
    cyc("md_drop_rec", mk(0, 0, 0, 1));
    cyc("md_drop_run", mk(0, 0, 0, 0));

    // Mult started one cycle before req survives the flush.
    E_md_start = 1'b1; E_md_kind = 1'b0;
    cyc("mult_start", mk(0, 0, 1, 0));
    E_md_start = 1'b0; int_req = 1'b1;
    cyc("mult_req", mk(0, 1, 1, 0));
    int_req = 1'b0; D_is_md = 1'b1;
    cyc("mult_recover", mk(0, 0, 1, 1));
    D_is_md = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("mult_cnt%0d", i), mk(0, 0, 1, 0));
    cyc("mult_done", mk(0, 0, 0, 0));

    // Async reset mid-mult with md_cnt=3.
    E_md_start = 1'b1; E_md_kind = 1'b0; D_is_md = 1'b1;
    cyc("rst_mult_start", mk(1, 0, 1, 0));
    E_md_start = 1'b0;
    cyc("rst_cnt5", mk(1, 0, 1, 0));
    cyc("rst_cnt4", mk(1, 0, 1, 0));
    exp_q.push_back(mk(1, 0, 1, 0));
    #1;
    compare_out("rst_cnt3");
    #1;
    reset = 1'b0; int_req = 1'b1;
    now_chk("rst_async", mk(0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1; int_req = 1'b0;
    now_chk("rst_release", mk(0, 0, 0, 0));
    @(posedge clk);
    #1;
    cyc("rst_after", mk(0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/exception sequencer for the five-stage P7 pipeline.
- Drives the hold enable of the F-PC and F/D pipeline registers, the bubble (flush) of the D/E register, and the global exception request `req` that clears every pipeline register to the handler vector.
- Detects Tuse/Tnew data hazards and tracks the multiply/divide unit's busy interval with an internal countdown.
- Runs a small exception FSM that guarantees a clean one-cycle `req` and a one-cycle post-flush recovery.

Parameters:
MULT_CYCLES  5  busy cycles loaded for mult/multu
DIV_CYCLES  10  busy cycles loaded for div/divu
CNT_W  4  countdown width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
D_rs  input  5  D-stage source register rs
D_rt  input  5  D-stage source register rt
D_tuse_rs  input  2  cycles until D instr needs rs (0..2; 3 = rs unused)
D_tuse_rt  input  2  same for rt
D_is_md  input  1  D instr is mult/div/mfhi/mflo/mthi/mtlo
E_dst  input  5  E-stage destination register (0 = none)
E_tnew  input  2  cycles until E result is forwardable
M_dst  input  5  M-stage destination register (0 = none)
M_tnew  input  2  cycles until M result is forwardable
E_md_start  input  1  E instr starts an MDU operation this cycle
E_md_kind  input  1  0 = mult/multu, 1 = div/divu
int_req  input  1  exception/interrupt request from CP0 at M
stall  output  1  1 = hold F-PC and F/D register (their `en`)
E_flush  output  1  1 = load bubble into D/E register
req  output  1  exception flush to all pipeline registers
md_busy  output  1  MDU busy, including the start cycle
exc_state  output  1  0 = RUN, 1 = RECOVER (debug/observability)

Behaviour:
- Reset (reset=0, async):
  - md_cnt=0, state=RUN.
  - All outputs 0: stall=0, E_flush=0, req=0, md_busy=0, exc_state=0.
- Data-hazard stall (combinational):
  - stall_rs = (D_rs != 0) && ((D_rs == E_dst && E_tnew > D_tuse_rs) || (D_rs == M_dst && M_tnew > D_tuse_rs)).
  - stall_rt is the same expression using D_rt and D_tuse_rt.
  - Tuse = 3 never stalls, since Tnew ≤ 2.
  - Register 0 never causes a stall.
- MDU countdown (md_cnt, CNT_W bits):
  - When E_md_start=1, req=0 and md_cnt=0, load MULT_CYCLES or DIV_CYCLES according to E_md_kind.
  - Otherwise, if md_cnt != 0, decrement by 1 each cycle.
  - E_md_start while md_cnt != 0 is a protocol violation: ignore it and keep counting. The stall logic makes this case unreachable.
  - md_busy = (md_cnt != 0) || (E_md_start && !req).
  - stall_md = D_is_md && md_busy.
- Stall and flush:
  - stall = (stall_rs | stall_rt | stall_md) && !req.
  - E_flush = stall. Every held cycle inserts exactly one bubble.
- Exception FSM, states RUN / RECOVER:
  - RUN: req = int_req (combinational, same cycle). If int_req=1, next state is RECOVER.
  - RECOVER (exactly 1 cycle): req=0, int_req is masked, stall and E_flush forced to 0, next state RUN.
    - The pipeline is empty here; the handler fetch at 0x4180 must proceed.
  - req has priority over every stall: registers clear regardless of stall.
  - md_cnt is NOT cleared by req, because an MDU op already in flight completes. An E_md_start in the same cycle as req is dropped.
- Boundary cases:
  - md_cnt reaching 1 → stall_md still asserted that cycle; the D instr issues on the following cycle when md_cnt=0.
  - int_req held high across RECOVER → second req only on the first RUN cycle after RECOVER. Back-to-back req pulses are separated by ≥1 cycle.
  - reset deasserted mid-MDU-op → counter restarts from 0; no stale busy.

Decomposition:
- Shared package `pipe_ctrl_pkg`:
  - state encoding (RUN, RECOVER);
  - TUSE_NONE=2'd3;
  - MD_MULT/MD_DIV kind codes;
  - EXC_VECTOR 32'h0000_4180 (shared with the pipeline registers).
- One natural sub-module `md_busy_cnt`: countdown, load and md_busy generation.
- Hazard compare and FSM stay in the top module.

Test Plan:
- Load-use: E_dst=5, E_tnew=2, D_rs=5, D_tuse_rs=0 → stall=1, E_flush=1. Next cycle, with M_dst=5 and M_tnew=1, stall=1. Then M_tnew=0 → stall=0.
- Zero register: D_rs=0, E_dst=0, E_tnew=2, D_tuse_rs=0 → stall=0.
- Divide busy: E_md_start=1, E_md_kind=1, then D_is_md=1 held → md_busy=1 for 11 cycles (start + 10). stall=1 on those cycles, then stall=0.
- Exception during stall: stall_rs active and int_req=1 → req=1, stall=0 in that cycle. Next cycle exc_state=1, req=0 even with int_req still 1. Following cycle req=1 again.
- MDU vs req: E_md_start=1 with int_req=1 in the same cycle → md_busy=0, md_cnt stays 0. A mult started one cycle earlier keeps md_busy=1 through the req cycle.
- Async reset: assert reset=0 mid-mult with md_cnt=3, between clock edges → all outputs 0 immediately. After release, md_busy=0 and state=RUN.
